// File: rtl/btn_debounce_if.sv
// Button bundle between the raw pins and the debounced event consumers.
// The slave side is the debouncer; the master side drives pins and reads events.
interface btn_debounce_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_long;

  modport master (
    output btn_in,
    input  btn_level, btn_press, btn_release, btn_long
  );

  modport slave (
    input  btn_in,
    output btn_level, btn_press, btn_release, btn_long
  );
endinterface

// File: rtl/btn_debounce.sv
// Per-channel button debouncer: 2-flop sync, stable-run counter, and a
// press/long/release FSM producing a clean level plus single-cycle event pulses.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_RELEASED | debounced level 0, waiting for an accepted rise
// ST_PRESSED  | debounced level 1, lcnt counting towards the long-press mark
// ST_LONG     | long pulse already issued for this press, lcnt held
module btn_debounce #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 100_000_000,
  parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
  input logic           sys_clk,
  input logic           sys_rst_n,
  btn_debounce_if.slave bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] D_TC = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] L_TC = LW'(LONG_CYCLES - 1);
  localparam logic REL_PIN = BTN_ACTIVE_LOW;

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_PRESSED  = 2'd1,
    ST_LONG     = 2'd2
  } state_t;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic          sync1;
    logic          sync2;
    logic          s;
    logic          accept;
    logic [DW-1:0] dcnt;
    logic [LW-1:0] lcnt;
    state_t        state;
    logic          level_q;
    logic          press_q;
    logic          rel_q;
    logic          long_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        sync1 <= REL_PIN;
        sync2 <= REL_PIN;
      end else begin
        sync1 <= bus.btn_in[i];
        sync2 <= sync1;
      end
    end

    assign s      = sync2 ^ REL_PIN;
    assign accept = (s != level_q) && (dcnt == D_TC);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        dcnt    <= '0;
        lcnt    <= '0;
        state   <= ST_RELEASED;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;

        // any return to the current level throws away the partial run
        if (s == level_q)
          dcnt <= '0;
        else if (accept) begin
          dcnt    <= '0;
          level_q <= ~level_q;
        end else
          dcnt <= dcnt + 1'b1;

        case (state)
          ST_RELEASED: begin
            if (accept) begin
              state   <= ST_PRESSED;
              press_q <= 1'b1;
              lcnt    <= '0;
            end
          end
          ST_PRESSED: begin
            // a release on the terminal cycle beats the long pulse
            if (accept) begin
              state <= ST_RELEASED;
              rel_q <= 1'b1;
            end else begin
              lcnt <= lcnt + 1'b1;
              if (lcnt == L_TC) begin
                long_q <= 1'b1;
                state  <= ST_LONG;
              end
            end
          end
          ST_LONG: begin
            if (accept) begin
              state <= ST_RELEASED;
              rel_q <= 1'b1;
            end
          end
          default: state <= ST_RELEASED;
        endcase
      end
    end

    assign bus.btn_level[i]   = level_q;
    assign bus.btn_press[i]   = press_q;
    assign bus.btn_release[i] = rel_q;
    assign bus.btn_long[i]    = long_q;
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: reference model from stable-window rules, vector table,
// hand sequences for latency/reset corners, and a randomized run.
module tb_btn_debounce;
  localparam int N = 4;
  localparam int D = 8;
  localparam int L = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] btn = '0;

  always #5 clk = ~clk;

  btn_debounce_if #(.N_BTN(N)) bus ();
  btn_debounce_if #(.N_BTN(N)) bus_al ();

  assign bus.btn_in    = btn;
  assign bus_al.btn_in = ~btn;

  btn_debounce #(.N_BTN(N), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .BTN_ACTIVE_LOW(1'b0)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus)
  );

  btn_debounce #(.N_BTN(N), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .BTN_ACTIVE_LOW(1'b1)) dut_al (
    .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus_al)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model state: raw pin history plus press age per channel
  logic [N-1:0] hist[$];
  logic [N-1:0] m_level = '0;
  logic [N-1:0] e_press = '0, e_rel = '0, e_long = '0;
  int age[N];

  int press_cnt[N], rel_cnt[N], long_cnt[N];
  int press_cyc[N], rel_cyc[N], long_cyc[N];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pack4(input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic [N-1:0] c, input logic [N-1:0] d);
    return int'({a, b, c, d});
  endfunction

  task automatic clear_counts();
    for (int c = 0; c < N; c++) begin
      press_cnt[c] = 0; rel_cnt[c] = 0; long_cnt[c] = 0;
      press_cyc[c] = -1; rel_cyc[c] = -1; long_cyc[c] = -1;
    end
  endtask

  // A level change is accepted at edge n when the D synchronized samples seen
  // at edges n-1..n-D all differ from the current level; the synchronized
  // sample after edge e is the raw pin captured at edge e-1.
  bit ad;
  int idx;
  logic v;
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      hist.delete();
      m_level = '0;
      e_press = '0; e_rel = '0; e_long = '0;
    end else begin
      hist.push_back(btn);
      while (hist.size() > D + 2) void'(hist.pop_front());
      e_press = '0; e_rel = '0; e_long = '0;
      for (int c = 0; c < N; c++) begin
        ad = 1'b1;
        for (int j = 1; j <= D; j++) begin
          idx = hist.size() - 1 - (j + 1);
          v = (idx >= 0) ? hist[idx][c] : 1'b0;
          if (v == m_level[c]) ad = 1'b0;
        end
        if (ad) begin
          if (!m_level[c]) begin
            m_level[c] = 1'b1; e_press[c] = 1'b1; age[c] = 0;
          end else begin
            m_level[c] = 1'b0; e_rel[c] = 1'b1;
          end
        end else if (m_level[c]) begin
          age[c]++;
          if (age[c] == L) e_long[c] = 1'b1;
        end
      end
    end
    #1;
    chk("outputs_main", pack4(bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_long),
        pack4(m_level, e_press, e_rel, e_long));
    chk("outputs_active_low", pack4(bus_al.btn_level, bus_al.btn_press, bus_al.btn_release, bus_al.btn_long),
        pack4(m_level, e_press, e_rel, e_long));
    for (int c = 0; c < N; c++) begin
      if (bus.btn_press[c])   begin press_cnt[c]++; press_cyc[c] = cyc; end
      if (bus.btn_release[c]) begin rel_cnt[c]++;   rel_cyc[c] = cyc;   end
      if (bus.btn_long[c])    begin long_cnt[c]++;  long_cyc[c] = cyc;  end
    end
  end

  typedef struct {
    string name;
    int    ch;
    int    nruns;
    int    runs[5];
    int    exp_press;
    int    exp_rel;
    int    exp_long;
  } vec_t;

  vec_t vt[8];

  task automatic drive_for(input int ch, input logic val, input int cycles);
    @(negedge clk);
    btn[ch] = val;
    repeat (cycles - 1) @(negedge clk);
  endtask

  int k, m, k2;
  int kc[N];

  initial begin
    vt[0] = '{"bounce_3_2_5_1", 1, 5, '{3, 2, 5, 1, 20}, 1, 1, 0};
    vt[1] = '{"glitch_7",       0, 1, '{7, 0, 0, 0, 0},  0, 0, 0};
    vt[2] = '{"pulse_8",        0, 1, '{8, 0, 0, 0, 0},  1, 1, 0};
    vt[3] = '{"hold_32",        2, 1, '{32, 0, 0, 0, 0}, 1, 1, 0};
    vt[4] = '{"hold_33",        2, 1, '{33, 0, 0, 0, 0}, 1, 1, 1};
    vt[5] = '{"hold_69",        2, 1, '{69, 0, 0, 0, 0}, 1, 1, 1};
    vt[6] = '{"low_glitch_3",   3, 3, '{10, 3, 10, 0, 0}, 1, 1, 0};
    vt[7] = '{"low_glitch_7",   1, 3, '{8, 7, 10, 0, 0},  1, 1, 0};
    clear_counts();

    // reset held with pins toggling
    repeat (6) begin
      @(negedge clk);
      btn = N'($urandom);
    end
    chk("reset_outputs", pack4(bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_long), 0);
    @(negedge clk);
    btn = '0;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

    // clean press / release on channel 0
    clear_counts();
    @(negedge clk);
    btn[0] = 1'b1;
    k = cyc + 1;
    repeat (20) @(negedge clk);
    chk("press0_latency", press_cyc[0] - k, 9);
    chk("press0_count", press_cnt[0], 1);
    chk("press_other_ch", press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
    btn[0] = 1'b0;
    m = cyc + 1;
    repeat (20) @(negedge clk);
    chk("release0_latency", rel_cyc[0] - m, 9);
    chk("release0_count", rel_cnt[0], 1);

    // vector table: run-length patterns and resulting pulse counts
    for (int t = 0; t < 8; t++) begin
      clear_counts();
      for (int r = 0; r < vt[t].nruns; r++)
        drive_for(vt[t].ch, (r % 2 == 0), vt[t].runs[r]);
      drive_for(vt[t].ch, 1'b0, 50);
      chk({vt[t].name, "_press"},   press_cnt[vt[t].ch], vt[t].exp_press);
      chk({vt[t].name, "_release"}, rel_cnt[vt[t].ch],   vt[t].exp_rel);
      chk({vt[t].name, "_long"},    long_cnt[vt[t].ch],  vt[t].exp_long);
    end

    // long press timing on channel 2
    clear_counts();
    @(negedge clk);
    btn[2] = 1'b1;
    repeat (80) @(negedge clk);
    chk("long2_after_press", long_cyc[2] - press_cyc[2], L);
    chk("long2_count", long_cnt[2], 1);
    btn[2] = 1'b0;
    repeat (20) @(negedge clk);
    chk("long2_release", rel_cnt[2], 1);

    // async reset mid-press on channel 3 with lcnt at 20
    clear_counts();
    @(negedge clk);
    btn[3] = 1'b1;
    k = cyc + 1;
    while (cyc < k + 9 + 20) @(posedge clk);
    #2;
    chk("rst_mid_press_seen", press_cnt[3], 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_main", pack4(bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_long), 0);
    chk("rst_async_al", pack4(bus_al.btn_level, bus_al.btn_press, bus_al.btn_release, bus_al.btn_long), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    k2 = cyc + 1;
    while (cyc < k2 + 15) @(posedge clk);
    #2;
    chk("rst_no_release", rel_cnt[3], 0);
    chk("rst_repress_count", press_cnt[3], 2);
    chk("rst_repress_latency", press_cyc[3] - k2, 9);
    drive_for(3, 1'b0, 20);

    // staggered presses on all channels
    clear_counts();
    for (int c = 0; c < N; c++) begin
      @(negedge clk);
      btn[c] = 1'b1;
      kc[c] = cyc + 1;
    end
    repeat (20) @(negedge clk);
    for (int c = 0; c < N; c++) chk($sformatf("concurrent_press%0d", c), press_cyc[c] - kc[c], 9);
    btn = '0;
    repeat (20) @(negedge clk);
    for (int c = 0; c < N; c++) chk($sformatf("concurrent_release%0d", c), rel_cnt[c], 1);

    // randomized activity; the per-cycle model comparison does the checking
    for (int p = 0; p < 3000; p++) begin
      @(negedge clk);
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, (p < 1500) ? 9 : 39) == 0) btn[c] = ~btn[c];
      if (p == 2200) rst_n = 1'b0;
      if (p == 2203) rst_n = 1'b1;
    end
    btn = '0;
    repeat (30) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
